// File: rtl/ifid_queue_pkg.sv
// ifid_queue_pkg: bubble constants and entry layout shared by the IF/ID queue
package ifid_queue_pkg;
  localparam logic [63:0] PC_INIT = 64'h0;
  localparam logic [31:0] ZERO_INST = 32'h0;
  localparam logic JUMP_DISABLE = 1'b0;
  localparam logic TRUE_V = 1'b1;
  localparam logic FALSE_V = 1'b0;
  // entry packs {pc, inst, pc_plus_4, jump_ena, jump_pc}, MSB first
  function automatic int entry_w(int addr_w, int inst_w);
    return 3 * addr_w + inst_w + 1;
  endfunction
  localparam int ENTRY_W = entry_w(64, 32);
endpackage

// File: rtl/ifid_fifo_mem.sv
// ifid_fifo_mem: DEPTH x W register array, one write port, one async read port
module ifid_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W = 225
) (
  input  logic                     cpu_clk_50M,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge cpu_clk_50M)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ifid_queue.sv
// ifid_queue: IF/ID decoupling queue with valid/ready on both sides and one-cycle flush
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  input  logic [ADDR_W-1:0]        if_pc_plus_4,
  input  logic                     if_jump_ena,
  input  logic [ADDR_W-1:0]        if_jump_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic [ADDR_W-1:0]        id_pc_plus_4,
  output logic                     id_jump_ena,
  output logic [ADDR_W-1:0]        id_jump_pc,
  input  logic                     flush,
  input  logic                     excep_flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = entry_w(ADDR_W, INST_W);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] wdata, rdata;
  logic [ADDR_W-1:0] h_pc, h_pc_plus_4, h_jump_pc;
  logic [INST_W-1:0] h_inst;
  logic h_jump_ena, push, pop;
  assign if_ready = (count == FULL_CNT) ? FALSE_V : TRUE_V;
  assign id_valid = (count == '0) ? FALSE_V : TRUE_V;
  assign push = if_valid & if_ready;
  assign pop = id_valid & id_ready;
  assign wdata = {if_pc, if_inst, if_pc_plus_4, if_jump_ena, if_jump_pc};
  assign {h_pc, h_inst, h_pc_plus_4, h_jump_ena, h_jump_pc} = rdata;
  ifid_fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .cpu_clk_50M(cpu_clk_50M),
    .we(push),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || flush || excep_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
  // bubble outputs while empty so decode never sees stale storage
  always_comb begin
    id_pc = id_valid ? h_pc : ADDR_W'(PC_INIT);
    id_inst = id_valid ? h_inst : INST_W'(ZERO_INST);
    id_pc_plus_4 = id_valid ? h_pc_plus_4 : ADDR_W'(PC_INIT);
    id_jump_ena = id_valid ? h_jump_ena : JUMP_DISABLE;
    id_jump_pc = id_valid ? h_jump_pc : ADDR_W'(PC_INIT);
  end
endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed checks of the IF/ID queue with DEPTH=4
module tb_ifid_queue;
  logic cpu_clk_50M = 0;
  logic cpu_rst, if_valid, if_ready, if_jump_ena, id_valid, id_ready, id_jump_ena, flush, excep_flush;
  logic [63:0] if_pc, if_pc_plus_4, if_jump_pc, id_pc, id_pc_plus_4, id_jump_pc;
  logic [31:0] if_inst, id_inst;
  logic [2:0] count;
  int checks = 0, errors = 0;

  ifid_queue #(.DEPTH(4), .ADDR_W(64), .INST_W(32)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_pc_plus_4(if_pc_plus_4), .if_jump_ena(if_jump_ena), .if_jump_pc(if_jump_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_pc_plus_4(id_pc_plus_4), .id_jump_ena(id_jump_ena), .id_jump_pc(id_jump_pc),
    .flush(flush), .excep_flush(excep_flush), .count(count)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic step();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic offer(input logic v, input logic [63:0] pc);
    if_valid = v;
    if_pc = pc;
    if_pc_plus_4 = pc + 64'd4;
    if_inst = pc[31:0] ^ 32'h00000013;
    if_jump_ena = 1'b1;
    if_jump_pc = pc + 64'h100;
  endtask

  task automatic test_reset();
    cpu_rst = 1; flush = 0; excep_flush = 0; id_ready = 0;
    offer(0, 64'h0);
    step(); step();
    cpu_rst = 0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b want 0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
    checks++; if (id_pc !== 64'h0) begin errors++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_pass_through();
    id_ready = 1;
    if_valid = 1; if_pc = 64'h80000000; if_inst = 32'h00100093; if_pc_plus_4 = 64'h80000004;
    if_jump_ena = 1; if_jump_pc = 64'h80001000;
    step();
    if_valid = 0; if_pc = 64'hdead; if_inst = 32'hffffffff;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL pass_id_valid got %0b want 1", id_valid); end
    checks++; if (id_pc !== 64'h80000000) begin errors++; $display("FAIL pass_id_pc got %h want 80000000", id_pc); end
    checks++; if (id_inst !== 32'h00100093) begin errors++; $display("FAIL pass_id_inst got %h want 00100093", id_inst); end
    checks++; if (id_pc_plus_4 !== 64'h80000004) begin errors++; $display("FAIL pass_pc4 got %h want 80000004", id_pc_plus_4); end
    checks++; if (id_jump_ena !== 1'b1) begin errors++; $display("FAIL pass_jump_ena got %0b want 1", id_jump_ena); end
    checks++; if (id_jump_pc !== 64'h80001000) begin errors++; $display("FAIL pass_jump_pc got %h want 80001000", id_jump_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL pass_count1 got %0d want 1", count); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL pass_count0 got %0d want 0", count); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL pass_drained got %0b want 0", id_valid); end
  endtask

  task automatic test_fill_stall();
    id_ready = 0;
    for (int i = 0; i < 4; i++) begin
      offer(1, 64'h80000000 + 64'(4 * i));
      step();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
      checks++; if (id_pc !== 64'h80000000) begin errors++; $display("FAIL fill_head_held got %h want 80000000", id_pc); end
    end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fill_if_ready got %0b want 0", if_ready); end
    offer(1, 64'h80000010);
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_count got %0d want 4", count); end
    offer(0, 64'h0);
    id_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (id_pc !== 64'h80000000 + 64'(4 * i)) begin errors++; $display("FAIL fill_order got %h want %h", id_pc, 64'h80000000 + 64'(4 * i)); end
      step();
    end
    checks++; if (id_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fill_drain got valid=%0b count=%0d want 0/0", id_valid, count); end
  endtask

  task automatic test_simultaneous();
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      offer(1, 64'hA0 + 64'(4 * i));
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL simul_pre_count got %0d want 3", count); end
    id_ready = 1;
    offer(1, 64'hAC);
    step();
    checks++; if (count !== 3'd3 || id_pc !== 64'hA4) begin errors++; $display("FAIL simul_3a got count=%0d head=%h want 3/a4", count, id_pc); end
    offer(1, 64'hB0);
    step();
    checks++; if (count !== 3'd3 || id_pc !== 64'hA8) begin errors++; $display("FAIL simul_3b got count=%0d head=%h want 3/a8", count, id_pc); end
    id_ready = 0;
    offer(1, 64'hB4);
    step();
    checks++; if (count !== 3'd4 || if_ready !== 1'b0) begin errors++; $display("FAIL simul_full got count=%0d if_ready=%0b want 4/0", count, if_ready); end
    id_ready = 1;
    offer(1, 64'hC0);
    step();
    checks++; if (count !== 3'd3 || id_pc !== 64'hAC) begin errors++; $display("FAIL simul_full_pop got count=%0d head=%h want 3/ac", count, id_pc); end
    offer(0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] e;
      e = (i == 0) ? 64'hAC : (i == 1) ? 64'hB0 : 64'hB4;
      checks++; if (id_pc !== e) begin errors++; $display("FAIL simul_order got %h want %h", id_pc, e); end
      step();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL simul_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      id_ready = 0;
      offer(1, 64'h400); step();
      offer(1, 64'h404); step();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush%0d_pre got %0d want 2", k, count); end
      offer(1, 64'h408);
      id_ready = 1;
      flush = (k == 0);
      excep_flush = (k == 1);
      step();
      flush = 0; excep_flush = 0;
      offer(0, 64'h0);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush%0d_count got %0d want 0", k, count); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush%0d_valid got %0b want 0", k, id_valid); end
      checks++; if (id_jump_ena !== 1'b0) begin errors++; $display("FAIL flush%0d_jump got %0b want 0", k, id_jump_ena); end
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush%0d_if_ready got %0b want 1", k, if_ready); end
      step();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush%0d_stay got %0d want 0", k, count); end
    end
  endtask

  task automatic test_wrap();
    int n, sent, recv, mcount;
    logic do_push, do_pop;
    n = 3 * 4 + 1;
    sent = 0; recv = 0; mcount = 0;
    for (int cyc = 0; cyc < 400 && recv < n; cyc++) begin
      offer(sent < n, 64'h1000 + 64'(8 * sent));
      id_ready = ($urandom_range(0, 3) != 0);
      do_push = if_valid && mcount < 4;
      do_pop = id_ready && mcount > 0;
      checks++; if (if_ready !== (mcount < 4) || id_valid !== (mcount > 0)) begin errors++; $display("FAIL wrap_flags got rdy=%0b vld=%0b want mcount=%0d", if_ready, id_valid, mcount); end
      if (do_pop) begin
        checks++; if (id_pc !== 64'h1000 + 64'(8 * recv)) begin errors++; $display("FAIL wrap_order got %h want %h", id_pc, 64'h1000 + 64'(8 * recv)); end
        recv++;
      end
      if (do_push) sent++;
      mcount = mcount + int'(do_push) - int'(do_pop);
      step();
    end
    offer(0, 64'h0);
    checks++; if (recv !== n) begin errors++; $display("FAIL wrap_timeout got %0d pops want %0d", recv, n); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_final_count got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_stall();
    test_simultaneous();
    test_flush();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised IF/ID decoupling queue that replaces the single-entry IF/ID pipeline register.
- Buffers up to DEPTH fetched instructions, each with its PC, PC+4 and branch-prediction info.
- Uses a valid/ready handshake on both sides, so a fetch that completes during a decode stall is retained rather than dropped.
- Sits between the AXI instruction-fetch stage and the decoder. Branch-mispredict flush and exception flush empty it in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, 64, PC width
- INST_W, 32, instruction width

Ports:
- cpu_clk_50M  in  1  clock; all state updates on rising edge
- cpu_rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch stage offers an entry (AXI handshake done)
- if_ready  out  1  queue can accept; equals !full (no combinational path from id_ready)
- if_pc  in  ADDR_W  PC of offered instruction
- if_inst  in  INST_W  instruction word
- if_pc_plus_4  in  ADDR_W  PC+4
- if_jump_ena  in  1  predictor says taken
- if_jump_pc  in  ADDR_W  predicted target
- id_valid  out  1  head entry valid; equals !empty
- id_ready  in  1  decoder consumes head this cycle; low = id stall or data-read stall
- id_pc  out  ADDR_W  head PC
- id_inst  out  INST_W  head instruction
- id_pc_plus_4  out  ADDR_W  head PC+4
- id_jump_ena  out  1  head predicted-taken
- id_jump_pc  out  ADDR_W  head predicted target
- flush  in  1  branch-mispredict flush
- excep_flush  in  1  exception flush
- count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage is a circular array of DEPTH entries, with wr_ptr, rd_ptr and count registers. Pointers are clog2(DEPTH) bits and wrap naturally.
- push = if_valid & if_ready.
- pop = id_valid & id_ready.
- Reset (cpu_rst=1 at an edge): wr_ptr=rd_ptr=count=0. Entry contents are don't-care.
- Outputs after reset: id_valid=0, if_ready=1, count=0.
- Output masking: when id_valid=0, id_pc=PC_INIT, id_inst=ZERO_INST, id_pc_plus_4=PC_INIT, id_jump_ena=JUMP_DISABLE, id_jump_pc=PC_INIT, so the decoder sees a bubble.
- When id_valid=1, id_* are taken directly from the head entry's storage registers, with no combinational path from if_*.
- Latency: an entry pushed at edge N appears on id_* from edge N onward if the queue was empty. Minimum fill-to-use latency is 1 cycle, matching the old register.
- Throughput: 1 entry/cycle sustained while the queue is neither empty nor full.
- Priority at each edge: cpu_rst > (flush | excep_flush) > normal operation.
- Flush: wr_ptr=rd_ptr=count=0. Any push or pop in the same cycle is discarded, so the fetch entry offered in the flush cycle is NOT stored.
- Normal operation:
  - push only: write at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop together: both pointers advance and count is unchanged. This is legal at any count where if_ready=1, including count=DEPTH-1 (queue stays at DEPTH-1).
- Full (count=DEPTH): if_ready=0, and if_valid is ignored. The fetch stage must hold its request.
- Because of the !full rule, a simultaneous pop does not enable a push while full; the push lands the next cycle.
- Empty (count=0): id_valid=0, and id_ready is ignored; no underflow.
- Stall (id_ready=0): the head entry and all id_* outputs are held stable. Pushes continue until full.
- Reset or flush mid-burst: takes effect in the same edge and overrides any pending push or pop.
- No assertion of if_valid is required after a flush. The fetch stage re-fetches from the redirected PC.

Decomposition:
- Shared defines: PC_INIT, ZERO_INST, JUMP_DISABLE, TRUE_V/FALSE_V, plus an ifid_entry field layout (pc, inst, pc_plus_4, jump_ena, jump_pc) as a packed width constant.
- One natural sub-module: ifid_fifo_mem, the DEPTH x ENTRY_W register array with one write and one read port.
- Pointer, count and flush control stay in ifid_queue.

Test Plan:
- Reset then idle: cpu_rst=1 for 2 cycles, then 0 -> id_valid=0, id_inst=ZERO_INST, if_ready=1, count=0.
- Single pass-through: push pc=0x80000000, inst=0x00100093 with id_ready=1 -> id_valid=1 next cycle with those values, popped the following edge, count back to 0.
- Fill under stall (DEPTH=4): id_ready=0, push pc 0x80000000..0x8000000C -> count=4, if_ready=0. A fifth if_valid is not stored. Releasing id_ready yields 4 pops in order 0x..00, 04, 08, 0C.
- Simultaneous push/pop at count=3 -> count stays 3 and order is preserved. At count=4 with id_ready=1 and if_valid=1, only the pop occurs, giving count=3.
- Flush with push: count=2, then flush=1 with if_valid=1 -> next cycle count=0, id_valid=0, id_jump_ena=0. Repeat with excep_flush and confirm the same result.
- Wrap-around: 3*DEPTH+1 streaming pushes and pops with random id_ready gaps -> output PC sequence equals input sequence, and no entry is lost or duplicated.
